// File: rtl/iterative_multiplier.sv
// iterative_multiplier: shift-add multiplier, one partial product per clock, signed or unsigned.
module iterative_multiplier #(
  parameter int p_data_width = 4
) (
  input  logic                        i_w_clk,
  input  logic                        i_w_reset,
  input  logic [p_data_width-1:0]     i_w_a,
  input  logic [p_data_width-1:0]     i_w_b,
  input  logic                        i_w_signed,
  input  logic                        i_w_start,
  output logic                        o_w_busy,
  output logic                        o_w_done,
  output logic [2*p_data_width-1:0]   o_w_out
);
  localparam int N  = p_data_width;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [2*N-1:0] a_q, a_d, acc_q, acc_d, acc_nx, out_q, out_d;
  logic [N-1:0] b_q, b_d, a_mag, b_mag;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d;
  // Signed operands are reduced to magnitudes; the sign is reapplied once at the end.
  assign a_mag = (i_w_signed && i_w_a[N-1]) ? -i_w_a : i_w_a;
  assign b_mag = (i_w_signed && i_w_b[N-1]) ? -i_w_b : i_w_b;
  assign acc_nx = acc_q + (b_q[0] ? a_q : '0);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    out_d   = out_q;
    if (i_w_start && state_q != RUN) begin
      state_d = RUN;
      a_d     = {{N{1'b0}}, a_mag};
      b_d     = b_mag;
      acc_d   = '0;
      cnt_d   = '0;
      neg_d   = i_w_signed && (i_w_a[N-1] ^ i_w_b[N-1]);
    end else if (state_q == RUN) begin
      acc_d = acc_nx;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(N-1)) begin
        state_d = DONE;
        out_d   = neg_q ? -acc_nx : acc_nx;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      out_q   <= out_d;
    end
  end
  assign o_w_busy = state_q == RUN;
  assign o_w_done = state_q == DONE;
  assign o_w_out  = out_q;
endmodule

// File: tb/tb_iterative_multiplier.sv
// tb_iterative_multiplier: directed and random checks of N=4 and N=8 multipliers against an arithmetic model.
module tb_iterative_multiplier;
  logic clk = 0, rst = 1;
  logic [3:0] a4 = 0, b4 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic s4 = 0, s8 = 0, st4 = 0, st8 = 0;
  logic busy4, done4, busy8, done8;
  logic [7:0] out4;
  logic [15:0] out8;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  iterative_multiplier #(.p_data_width(4)) dut4 (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_a(a4), .i_w_b(b4), .i_w_signed(s4),
    .i_w_start(st4), .o_w_busy(busy4), .o_w_done(done4), .o_w_out(out4));
  iterative_multiplier #(.p_data_width(8)) dut8 (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_a(a8), .i_w_b(b8), .i_w_signed(s8),
    .i_w_start(st8), .o_w_busy(busy8), .o_w_done(done8), .o_w_out(out8));
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] ref_mul(input int n, input logic [7:0] a, input logic [7:0] b, input logic s);
    longint one = 1, av, bv, m;
    av = longint'(a) & ((one << n) - 1);
    bv = longint'(b) & ((one << n) - 1);
    if (s && av >= (one << (n - 1))) av -= one << n;
    if (s && bv >= (one << (n - 1))) bv -= one << n;
    m = (av * bv) & ((one << (2 * n)) - 1);
    return 16'(m);
  endfunction
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s, input string tag);
    logic [15:0] exp = ref_mul(4, {4'b0, a}, {4'b0, b}, s);
    @(negedge clk); a4 = a; b4 = b; s4 = s; st4 = 1;
    @(posedge clk);
    @(negedge clk); st4 = 0; a4 = ~a; b4 = ~b; s4 = ~s;
    for (int i = 0; i < 4; i++) begin
      check({tag, " busy4"}, 16'(busy4), 16'd1);
      check({tag, " nodone4"}, 16'(done4), 16'd0);
      @(negedge clk);
    end
    check({tag, " done4"}, 16'(done4), 16'd1);
    check({tag, " idle4"}, 16'(busy4), 16'd0);
    check({tag, " out4"}, 16'(out4), exp);
    @(negedge clk);
    check({tag, " pulse4"}, 16'(done4), 16'd0);
    check({tag, " hold4"}, 16'(out4), exp);
  endtask
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] exp = ref_mul(8, a, b, s);
    @(negedge clk); a8 = a; b8 = b; s8 = s; st8 = 1;
    @(posedge clk);
    @(negedge clk); st8 = 0; a8 = $urandom; b8 = $urandom;
    for (int i = 0; i < 8; i++) begin
      check("busy8", 16'({busy8, done8}), 16'b10);
      @(negedge clk);
    end
    check("done8", 16'({busy8, done8}), 16'b01);
    check("out8", out8, exp);
    @(negedge clk);
    check("pulse8", 16'(done8), 16'd0);
  endtask
  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    check("rst out4", 16'(out4), 16'd0);
    check("rst busy4", 16'(busy4), 16'd0);
    check("rst done4", 16'(done4), 16'd0);
    check("rst out8", out8, 16'd0);
    rst = 0;
    op4(4'd15, 4'd15, 0, "u15x15");
    check("u15x15 val", 16'(out4), 16'h00E1);
    op4(4'b1000, 4'b1000, 1, "s-8x-8");
    check("s-8x-8 val", 16'(out4), 16'h0040);
    op4(4'b1000, 4'd7, 1, "s-8x7");
    check("s-8x7 val", 16'(out4), 16'h00C8);
    op4(4'b1111, 4'd2, 0, "u15x2");
    check("u15x2 val", 16'(out4), 16'h001E);
    op4(4'b1111, 4'd2, 1, "s-1x2");
    check("s-1x2 val", 16'(out4), 16'h00FE);
    op4(4'd0, 4'd13, 0, "u0x13");
    op4(4'd0, 4'd13, 1, "s0x13");
    // start held high across RUN; second operands latched in the DONE cycle
    @(negedge clk); a4 = 3; b4 = 5; s4 = 0; st4 = 1;
    @(posedge clk);
    @(negedge clk); a4 = 2; b4 = 2;
    for (int i = 0; i < 3; i++) begin
      check("b2b busy1", 16'({busy4, done4}), 16'b10);
      @(negedge clk);
    end
    check("b2b busy1 last", 16'({busy4, done4}), 16'b10);
    @(negedge clk);
    check("b2b done1", 16'({busy4, done4}), 16'b01);
    check("b2b out1", 16'(out4), 16'h000F);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b busy2", 16'({busy4, done4}), 16'b10);
      check("b2b hold", 16'(out4), 16'h000F);
    end
    st4 = 0;
    @(negedge clk);
    check("b2b done2", 16'({busy4, done4}), 16'b01);
    check("b2b out2", 16'(out4), 16'h0004);
    // reset mid-operation
    @(negedge clk); a4 = 9; b4 = 9; s4 = 0; st4 = 1;
    @(posedge clk);
    @(negedge clk); st4 = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    check("abort out", 16'(out4), 16'd0);
    check("abort busy", 16'(busy4), 16'd0);
    check("abort done", 16'(done4), 16'd0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done4 || busy4) cnt++;
    end
    check("idle quiet", 16'(cnt), 16'd0);
    op4(4'd2, 4'd3, 0, "after abort");
    check("after abort val", 16'(out4), 16'h0006);
    for (int i = 0; i < 40; i++) begin
      op4(4'($urandom), 4'($urandom), 1'($urandom), "rand4");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    op8(8'h80, 8'h80, 1);
    op8(8'hFF, 8'hFF, 0);
    op8(8'h00, 8'h9C, 1);
    for (int i = 0; i < 40; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
